pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage RV64 core: drives stall/flush on fetch, decode (idecode) and execute stages.
- Detects load-use hazards, squashes wrong-path instructions on EX-resolved redirects, stalls on data-memory wait.
- Runs a trap-sequencing FSM: drains older work, commits mcause/mepc, redirects fetch to mtvec.

Parameters:
- XLEN, 64, datapath/PC width.
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous, active-low reset
- id_rs1  in  5  rs1 field of the instruction currently at the decode input
- id_rs2  in  5  rs2 field of the instruction currently at the decode input
- id_uses_rs1  in  1  decode-input instruction reads rs1
- id_uses_rs2  in  1  decode-input instruction reads rs2
- ex_rd  in  5  rd of the instruction in EX (decode output register)
- ex_mem_read  in  1  instruction in EX is a load
- ex_redirect  in  1  EX resolved a taken branch or jump
- ex_target  in  XLEN  redirect target from EX
- ex_trap  in  1  instruction in EX carries a trap
- ex_trap_cause  in  4  trap cause from decode
- ex_pc  in  XLEN  PC of the instruction in EX
- mem_busy  in  1  MEM stage waiting on data memory
- mtvec  in  XLEN  trap vector base (direct mode)
- if_stall  out  1  hold PC and IF/ID register
- if_flush  out  1  squash the fetched instruction
- id_stall  out  1  idecode stall
- id_flush  out  1  idecode flush (NOP into EX)
- ex_stall  out  1  hold EX/MEM register
- pc_redirect  out  1  load PC from pc_target this cycle
- pc_target  out  XLEN  new PC
- trap_commit  out  1  one-cycle pulse: CSR file writes mcause/mepc
- mcause  out  4  captured trap cause
- mepc  out  XLEN  captured trapping PC

Behaviour:
- Reset (async assert, synchronous release): state = RUN, mcause = 0, mepc = 0. Every control output is 0 and pc_target = 0 while resetn is low.
- Control outputs are combinational from the registered state and the current inputs (zero latency). mcause and mepc are registered.
- FSM states: RUN, DRAIN, VECTOR.
- RUN priority, highest first:
  1. ex_trap: capture mcause <= ex_trap_cause and mepc <= ex_pc. Assert if_stall, id_flush. Go to DRAIN.
  2. ex_redirect: pc_redirect = 1, pc_target = ex_target, if_flush = 1, id_flush = 1. Stay in RUN.
  3. mem_busy: if_stall, id_stall and ex_stall all 1. No flushes.
  4. Load-use: ex_mem_read && ex_rd != 0 && ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd)). Assert if_stall = 1 and id_flush = 1, which inserts exactly one bubble. id_stall = 0.
  5. Otherwise all outputs 0.
- DRAIN:
  - if_stall = 1, id_flush = 1, ex_stall = mem_busy.
  - Stay while mem_busy = 1. Go to VECTOR when mem_busy = 0.
  - ex_trap and ex_redirect are ignored in DRAIN.
- VECTOR (exactly one cycle):
  - trap_commit = 1, pc_redirect = 1, pc_target = {mtvec[XLEN-1:2], 2'b00}, if_flush = 1, id_flush = 1.
  - Next state RUN.
- Simultaneous events:
  - ex_trap together with ex_redirect: trap wins, no redirect is issued.
  - Redirect together with load-use: redirect wins; the stalled instruction is wrong-path.
  - mem_busy together with load-use: only the full stall is applied; no bubble until mem_busy drops.
- rd = x0 never produces a hazard.
- Reset mid-DRAIN or mid-VECTOR: returns to RUN, trap_commit is not emitted.
- Minimum trap latency: ex_trap to trap_commit is 2 cycles (RUN -> DRAIN -> VECTOR) when mem_busy = 0.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: adds outputs perf_loaduse_cnt, perf_memstall_cnt and perf_flush_cnt, each CNT_W wide.
  - They increment on cycles where load-use, mem_busy or redirect respectively is the winning condition in RUN.
  - They wrap at 2^CNT_W and reset to 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Load-use: ex_mem_read = 1, ex_rd = 5, id_rs1 = 5, id_uses_rs1 = 1 -> if_stall = 1, id_flush = 1 for one cycle, then 0 once EX holds the bubble. Same with ex_rd = 0 -> no stall.
- Redirect: ex_redirect = 1, ex_target = 0x2000 -> pc_redirect = 1, pc_target = 0x2000, if_flush = 1, id_flush = 1 in the same cycle.
- Memory wait plus load-use: mem_busy high 3 cycles with a load-use condition present -> if_stall, id_stall and ex_stall = 1 for 3 cycles with id_flush = 0, then a 1-cycle bubble.
- Trap: ex_trap = 1, cause = 4'd2, ex_pc = 0x1010, mtvec = 0x8003, mem_busy high 2 cycles -> DRAIN for 3 cycles, then trap_commit = 1, mcause = 2, mepc = 0x1010, pc_target = 0x8000.
- Priority: ex_trap and ex_redirect together -> no pc_redirect that cycle, FSM enters DRAIN.
- Reset: resetn dropped while in DRAIN -> all outputs 0 immediately, no trap_commit after release, state RUN.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard / trap sequencer for the 5-stage RV64 core.
// Drives stall/flush for IF, ID and EX; detects load-use hazards,
// squashes wrong-path work on EX redirects, stalls on data-memory wait and
// sequences traps through RUN -> DRAIN -> VECTOR.
// Optional build macro HAZARD_PERF_EN adds load-use / mem-stall / flush
// event counters (CNT_W bits, wrapping).
module pipe_hazard_ctrl #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic [4:0]      ex_rd,
  input  logic            ex_mem_read,
  input  logic            ex_redirect,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_trap,
  input  logic [3:0]      ex_trap_cause,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            mem_busy,
  input  logic [XLEN-1:0] mtvec,
  output logic            if_stall,
  output logic            if_flush,
  output logic            id_stall,
  output logic            id_flush,
  output logic            ex_stall,
  output logic            pc_redirect,
  output logic [XLEN-1:0] pc_target,
  output logic            trap_commit,
  output logic [3:0]      mcause,
  output logic [XLEN-1:0] mepc
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_loaduse_cnt,
  output logic [CNT_W-1:0] perf_memstall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {RUN, DRAIN, VECTOR} state_t;

  state_t state, state_nxt;
  logic   load_use;
  logic   take_trap, win_redir, win_mem, win_lu;

  // Load in EX whose rd feeds the decode-input instruction; x0 never hazards.
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  // State register; reset always lands in RUN so a pending trap is dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= RUN;
    else         state <= state_nxt;
  end

  // Trap CSR capture on the RUN-state trap acceptance cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mcause <= 4'd0;
      mepc   <= '0;
    end else if (take_trap) begin
      mcause <= ex_trap_cause;
      mepc   <= ex_pc;
    end
  end

  // Next state and zero-latency control outputs, priority-encoded in RUN.
  always_comb begin
    state_nxt   = state;
    if_stall    = 1'b0;
    if_flush    = 1'b0;
    id_stall    = 1'b0;
    id_flush    = 1'b0;
    ex_stall    = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = '0;
    trap_commit = 1'b0;
    take_trap   = 1'b0;
    win_redir   = 1'b0;
    win_mem     = 1'b0;
    win_lu      = 1'b0;
    case (state)
      RUN: begin
        if (ex_trap) begin
          take_trap = 1'b1;
          if_stall  = 1'b1;
          id_flush  = 1'b1;
          state_nxt = DRAIN;
        end else if (ex_redirect) begin
          win_redir   = 1'b1;
          pc_redirect = 1'b1;
          pc_target   = ex_target;
          if_flush    = 1'b1;
          id_flush    = 1'b1;
        end else if (mem_busy) begin
          // Full freeze; a pending load-use bubble waits until memory returns.
          win_mem  = 1'b1;
          if_stall = 1'b1;
          id_stall = 1'b1;
          ex_stall = 1'b1;
        end else if (load_use) begin
          win_lu   = 1'b1;
          if_stall = 1'b1;
          id_flush = 1'b1;
        end
      end
      DRAIN: begin
        if_stall = 1'b1;
        id_flush = 1'b1;
        ex_stall = mem_busy;
        if (!mem_busy) state_nxt = VECTOR;
      end
      VECTOR: begin
        trap_commit = 1'b1;
        pc_redirect = 1'b1;
        pc_target   = mtvec & ~XLEN'(3);  // direct mode: 4-byte aligned base
        if_flush    = 1'b1;
        id_flush    = 1'b1;
        state_nxt   = RUN;
      end
      default: state_nxt = RUN;
    endcase
    // Quiesce every control output while reset is held.
    if (!resetn) begin
      if_stall    = 1'b0;
      if_flush    = 1'b0;
      id_stall    = 1'b0;
      id_flush    = 1'b0;
      ex_stall    = 1'b0;
      pc_redirect = 1'b0;
      pc_target   = '0;
      trap_commit = 1'b0;
      take_trap   = 1'b0;
      win_redir   = 1'b0;
      win_mem     = 1'b0;
      win_lu      = 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  // Event counters bump on the winning RUN condition; they wrap naturally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_loaduse_cnt  <= '0;
      perf_memstall_cnt <= '0;
      perf_flush_cnt    <= '0;
    end else begin
      if (win_lu)    perf_loaduse_cnt  <= perf_loaduse_cnt + 1'b1;
      if (win_mem)   perf_memstall_cnt <= perf_memstall_cnt + 1'b1;
      if (win_redir) perf_flush_cnt    <= perf_flush_cnt + 1'b1;
    end
  end
`else
  // Counters compiled out; the winner flags simply go unobserved.
  if (CNT_W == 0) begin : g_no_cnt
  end
  logic perf_unused;
  assign perf_unused = win_lu ^ win_mem ^ win_redir;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected control vectors are queued
// as each step is driven and popped/compared once outputs have settled.
module tb_pipe_hazard_ctrl;
  localparam int XLEN  = 64;
  localparam int CNT_W = 32;

  // Control bit masks: {if_stall,if_flush,id_stall,id_flush,ex_stall,pc_redirect,trap_commit}
  localparam logic [6:0] IFS = 7'b1000000;
  localparam logic [6:0] IFF = 7'b0100000;
  localparam logic [6:0] IDS = 7'b0010000;
  localparam logic [6:0] IDF = 7'b0001000;
  localparam logic [6:0] EXS = 7'b0000100;
  localparam logic [6:0] PCR = 7'b0000010;
  localparam logic [6:0] TC  = 7'b0000001;

  typedef struct packed {
    logic [6:0]      ctl;
    logic            chk_tgt;
    logic [XLEN-1:0] tgt;
    logic [3:0]      mc;
    logic [XLEN-1:0] me;
  } exp_t;

  logic clk = 1'b0, resetn = 1'b0;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, ex_trap, mem_busy;
  logic [XLEN-1:0] ex_target, ex_pc, mtvec;
  logic [3:0] ex_trap_cause;
  logic if_stall, if_flush, id_stall, id_flush, ex_stall, pc_redirect, trap_commit;
  logic [XLEN-1:0] pc_target, mepc;
  logic [3:0] mcause;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] perf_loaduse_cnt, perf_memstall_cnt, perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  pipe_hazard_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .ex_target(ex_target),
    .ex_trap(ex_trap), .ex_trap_cause(ex_trap_cause), .ex_pc(ex_pc), .mem_busy(mem_busy),
    .mtvec(mtvec),
    .if_stall(if_stall), .if_flush(if_flush), .id_stall(id_stall), .id_flush(id_flush),
    .ex_stall(ex_stall), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .trap_commit(trap_commit), .mcause(mcause), .mepc(mepc)
`ifdef HAZARD_PERF_EN
    , .perf_loaduse_cnt(perf_loaduse_cnt), .perf_memstall_cnt(perf_memstall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; ex_redirect = 1'b0; ex_target = '0;
    ex_trap = 1'b0; ex_trap_cause = 4'd0; ex_pc = '0; mem_busy = 1'b0;
  endtask

  task automatic load_use5();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
  endtask

  // Inputs are already driven (just after a negedge): queue expectation,
  // let outputs settle, pop and compare, then advance to the next negedge.
  task automatic step(input string tag, input logic [6:0] ctl, input logic chk_tgt,
                      input logic [XLEN-1:0] tgt, input logic [3:0] mc,
                      input logic [XLEN-1:0] me);
    exp_t e, g;
    sb.push_back('{ctl: ctl, chk_tgt: chk_tgt, tgt: tgt, mc: mc, me: me});
    #1;
    e = sb.pop_front();
    g.ctl     = {if_stall, if_flush, id_stall, id_flush, ex_stall, pc_redirect, trap_commit};
    g.chk_tgt = e.chk_tgt;
    g.tgt     = e.chk_tgt ? pc_target : e.tgt;
    g.mc      = mcause;
    g.me      = mepc;
    checks++;
    assert (g === e) else begin
      errors++;
      $error("FAIL %s: got ctl=%b tgt=%h mcause=%0d mepc=%h, want ctl=%b tgt=%h mcause=%0d mepc=%h",
             tag, g.ctl, pc_target, g.mc, g.me, e.ctl, e.tgt, e.mc, e.me);
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    mtvec = 64'h8003;
    // Reset held with hazard-provoking inputs: everything must read 0.
    ex_redirect = 1'b1; ex_target = 64'h2000; mem_busy = 1'b1; load_use5();
    @(negedge clk);
    step("reset_quiet", 7'd0, 1'b1, '0, 4'd0, '0);
    idle(); resetn = 1'b1;
    step("idle", 7'd0, 1'b0, '0, 4'd0, '0);

    load_use5();
    step("loaduse_rs1", IFS|IDF, 1'b0, '0, 4'd0, '0);
    ex_mem_read = 1'b0; ex_rd = 5'd0;
    step("loaduse_bubble", 7'd0, 1'b0, '0, 4'd0, '0);
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    step("loaduse_x0", 7'd0, 1'b0, '0, 4'd0, '0);
    idle(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
    step("loaduse_rs2", IFS|IDF, 1'b0, '0, 4'd0, '0);
    id_uses_rs2 = 1'b0;
    step("loaduse_rs2_unused", 7'd0, 1'b0, '0, 4'd0, '0);

    idle(); ex_redirect = 1'b1; ex_target = 64'h2000;
    step("redirect", PCR|IFF|IDF, 1'b1, 64'h2000, 4'd0, '0);
    load_use5();
    step("redirect_vs_loaduse", PCR|IFF|IDF, 1'b1, 64'h2000, 4'd0, '0);

    idle(); load_use5(); mem_busy = 1'b1;
    step("memwait_lu_1", IFS|IDS|EXS, 1'b0, '0, 4'd0, '0);
    step("memwait_lu_2", IFS|IDS|EXS, 1'b0, '0, 4'd0, '0);
    step("memwait_lu_3", IFS|IDS|EXS, 1'b0, '0, 4'd0, '0);
    mem_busy = 1'b0;
    step("memwait_then_bubble", IFS|IDF, 1'b0, '0, 4'd0, '0);
    idle();
    step("after_bubble", 7'd0, 1'b0, '0, 4'd0, '0);

    // Trap with a concurrent redirect: trap wins, no redirect.
    ex_trap = 1'b1; ex_trap_cause = 4'd2; ex_pc = 64'h1010;
    ex_redirect = 1'b1; ex_target = 64'h3000;
    step("trap_vs_redirect", IFS|IDF, 1'b0, '0, 4'd0, '0);
    idle(); mem_busy = 1'b1; ex_redirect = 1'b1; ex_target = 64'h3000;
    step("drain_busy_1", IFS|IDF|EXS, 1'b0, '0, 4'd2, 64'h1010);
    idle(); mem_busy = 1'b1; ex_trap = 1'b1; ex_trap_cause = 4'd9; ex_pc = 64'h5555;
    step("drain_busy_2", IFS|IDF|EXS, 1'b0, '0, 4'd2, 64'h1010);
    idle();
    step("drain_done", IFS|IDF, 1'b0, '0, 4'd2, 64'h1010);
    step("vector", TC|PCR|IFF|IDF, 1'b1, 64'h8000, 4'd2, 64'h1010);
    step("back_to_run", 7'd0, 1'b0, '0, 4'd2, 64'h1010);

    // Minimum-latency trap with a low-bit-dirty vector.
    mtvec = 64'hFFFF_FFFF_FFFF_0006;
    ex_trap = 1'b1; ex_trap_cause = 4'd3; ex_pc = 64'h1234;
    step("trap_fast", IFS|IDF, 1'b0, '0, 4'd2, 64'h1010);
    idle();
    step("drain_fast", IFS|IDF, 1'b0, '0, 4'd3, 64'h1234);
    step("vector_fast", TC|PCR|IFF|IDF, 1'b1, 64'hFFFF_FFFF_FFFF_0004, 4'd3, 64'h1234);

    // Reset in the middle of DRAIN.
    ex_trap = 1'b1; ex_trap_cause = 4'd5; ex_pc = 64'h2220;
    step("trap_pre_reset", IFS|IDF, 1'b0, '0, 4'd3, 64'h1234);
    idle(); mem_busy = 1'b1;
    step("drain_pre_reset", IFS|IDF|EXS, 1'b0, '0, 4'd5, 64'h2220);
    resetn = 1'b0;
    step("reset_in_drain", 7'd0, 1'b1, '0, 4'd0, '0);
    idle(); resetn = 1'b1;
    step("post_reset_1", 7'd0, 1'b0, '0, 4'd0, '0);
    step("post_reset_2", 7'd0, 1'b0, '0, 4'd0, '0);
    ex_redirect = 1'b1; ex_target = 64'h4000;
    step("post_reset_run", PCR|IFF|IDF, 1'b1, 64'h4000, 4'd0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop so the run can never hang.
  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule
